// File: rtl/haar_database_scheduler.sv
// Round-robin scheduler sharing one classifier-parameter ROM port among the cascade stage engines.
// Streams one parameter block per grant and tracks each stage's classifier pointer and count.
module haar_database_scheduler #(
    parameter int DATA_WIDTH_12            = 12,
    parameter int NUM_STAGES               = 24,
    parameter int NUM_PARAM_PER_CLASSIFIER = 18
) (
    input  logic                     clk_fpga,
    input  logic                     reset_fpga,
    input  logic                     i_restart,
    input  logic [NUM_STAGES-1:0]    i_req,
    input  logic [DATA_WIDTH_12-1:0] i_stage_base [NUM_STAGES],
    input  logic [DATA_WIDTH_12-1:0] i_num_classifier [NUM_STAGES],
    output logic                     o_rom_en,
    output logic [DATA_WIDTH_12-1:0] o_rom_addr,
    input  logic [DATA_WIDTH_12-1:0] i_rom_data,
    output logic [DATA_WIDTH_12-1:0] o_data,
    output logic                     o_data_valid,
    output logic [DATA_WIDTH_12-1:0] o_data_stage,
    output logic [DATA_WIDTH_12-1:0] o_data_index,
    output logic [NUM_STAGES-1:0]    o_grant,
    output logic [NUM_STAGES-1:0]    o_end_single_classifier,
    output logic [NUM_STAGES-1:0]    o_end_all_classifier,
    output logic                     o_busy
);

    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [DATA_WIDTH_12-1:0] ONE        = DATA_WIDTH_12'(1);
    localparam logic [DATA_WIDTH_12-1:0] LAST_WORD  = DATA_WIDTH_12'(NUM_PARAM_PER_CLASSIFIER - 1);
    localparam logic [DATA_WIDTH_12-1:0] BLOCK_LEN  = DATA_WIDTH_12'(NUM_PARAM_PER_CLASSIFIER);
    localparam logic [SW-1:0]            LAST_STAGE = SW'(NUM_STAGES - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                   state;
    logic [SW-1:0]            g;
    logic [SW-1:0]            last_grant;
    logic [DATA_WIDTH_12-1:0] word;
    logic [DATA_WIDTH_12-1:0] ptr [NUM_STAGES];
    logic [DATA_WIDTH_12-1:0] cnt [NUM_STAGES];
    logic                     init_load;
    logic                     restart_eff;

    logic [SW-1:0]            sel;
    logic [NUM_STAGES-1:0]    sel_oh;
    logic                     sel_found;

    // Request/grant: i_req is a level sampled only in IDLE; the grant is held
    // until the block's DRAIN completes, regardless of later i_req changes.
    assign restart_eff = i_restart | init_load;
    assign o_data      = i_rom_data;

    // Round-robin pick: first set request searching upward from last_grant+1 with wrap.
    always_comb begin
        int            t;
        logic [SW-1:0] idx;
        sel       = '0;
        sel_oh    = '0;
        sel_found = 1'b0;
        t         = 0;
        idx       = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            t = int'(last_grant) + 1 + i;
            if (t >= NUM_STAGES) t = t - NUM_STAGES;
            idx = SW'(t);
            if (!sel_found && i_req[idx]) begin
                sel         = idx;
                sel_oh[idx] = 1'b1;
                sel_found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) begin
            state                   <= IDLE;
            g                       <= '0;
            last_grant              <= LAST_STAGE;
            word                    <= '0;
            init_load               <= 1'b1;
            o_rom_en                <= 1'b0;
            o_rom_addr              <= '0;
            o_data_valid            <= 1'b0;
            o_data_stage            <= '0;
            o_data_index            <= '0;
            o_grant                 <= '0;
            o_end_single_classifier <= '0;
            o_end_all_classifier    <= '0;
            o_busy                  <= 1'b0;
            for (int s = 0; s < NUM_STAGES; s++) begin
                ptr[s] <= '0;
                cnt[s] <= '0;
            end
        end else begin
            o_end_single_classifier <= '0;
            o_end_all_classifier    <= '0;
            o_data_valid            <= o_rom_en;
            o_data_stage            <= DATA_WIDTH_12'(g);
            o_data_index            <= word;
            init_load               <= 1'b0;

            // Restart leaves the data pipeline alone so the in-flight word still emerges.
            if (restart_eff) begin
                state    <= IDLE;
                o_grant  <= '0;
                o_rom_en <= 1'b0;
                o_busy   <= 1'b0;
                for (int s = 0; s < NUM_STAGES; s++) begin
                    cnt[s] <= '0;
                    ptr[s] <= i_stage_base[s];
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (sel_found) begin
                            g          <= sel;
                            last_grant <= sel;
                            o_grant    <= sel_oh;
                            word       <= '0;
                            o_rom_en   <= 1'b1;
                            o_rom_addr <= ptr[sel];
                            o_busy     <= 1'b1;
                            state      <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (word == LAST_WORD) begin
                            o_rom_en <= 1'b0;
                            state    <= DRAIN;
                        end else begin
                            word       <= word + ONE;
                            o_rom_addr <= ptr[g] + word + ONE;
                        end
                    end
                    DRAIN: begin
                        o_end_single_classifier[g] <= 1'b1;
                        o_grant                    <= '0;
                        o_busy                     <= 1'b0;
                        state                      <= IDLE;
                        if (cnt[g] + ONE == i_num_classifier[g]) begin
                            o_end_all_classifier[g] <= 1'b1;
                            cnt[g]                  <= '0;
                            ptr[g]                  <= i_stage_base[g];
                        end else begin
                            cnt[g] <= cnt[g] + ONE;
                            ptr[g] <= ptr[g] + BLOCK_LEN;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_haar_database_scheduler.sv
// Directed bench for haar_database_scheduler: 4 stages, 3-word blocks, ROM returns addr+0x800.
module tb_haar_database_scheduler;

    localparam int DW = 12;
    localparam int NS = 4;
    localparam int NP = 3;
    localparam logic [DW-1:0] ROM_OFS = 12'h800;

    logic          clk_fpga = 1'b0;
    logic          reset_fpga;
    logic          i_restart;
    logic [NS-1:0] i_req;
    logic [DW-1:0] base [NS];
    logic [DW-1:0] num  [NS];
    logic          o_rom_en;
    logic [DW-1:0] o_rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] o_data;
    logic          o_data_valid;
    logic [DW-1:0] o_data_stage;
    logic [DW-1:0] o_data_index;
    logic [NS-1:0] o_grant;
    logic [NS-1:0] o_end_single;
    logic [NS-1:0] o_end_all;
    logic          o_busy;

    int total = 0;
    int bad   = 0;

    haar_database_scheduler #(
        .DATA_WIDTH_12(DW), .NUM_STAGES(NS), .NUM_PARAM_PER_CLASSIFIER(NP)
    ) dut (
        .clk_fpga(clk_fpga), .reset_fpga(reset_fpga), .i_restart(i_restart),
        .i_req(i_req), .i_stage_base(base), .i_num_classifier(num),
        .o_rom_en(o_rom_en), .o_rom_addr(o_rom_addr), .i_rom_data(rom_data),
        .o_data(o_data), .o_data_valid(o_data_valid), .o_data_stage(o_data_stage),
        .o_data_index(o_data_index), .o_grant(o_grant),
        .o_end_single_classifier(o_end_single), .o_end_all_classifier(o_end_all),
        .o_busy(o_busy)
    );

    always #5 clk_fpga = ~clk_fpga;

    // Synchronous ROM model, one cycle read latency.
    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) rom_data <= '0;
        else if (o_rom_en) rom_data <= o_rom_addr + ROM_OFS;
    end

    task automatic tick;
        @(posedge clk_fpga);
        #1;
    endtask

    task automatic test_reset;
        reset_fpga = 1'b0;
        i_restart  = 1'b0;
        i_req      = '0;
        repeat (2) tick();
        total++;
        if ({o_rom_en, o_busy, o_data_valid, o_grant, o_end_single, o_end_all,
             o_data, o_data_stage, o_data_index, o_rom_addr} !== '0) begin
            bad++;
            $display("FAIL reset_outputs en=%b busy=%b vld=%b grant=%b es=%b ea=%b data=%0d required all zero",
                     o_rom_en, o_busy, o_data_valid, o_grant, o_end_single, o_end_all, o_data);
        end
        reset_fpga = 1'b1;
        tick();
    endtask

    task automatic run_block(input int stg, input logic [DW-1:0] a0, input logic exp_all);
        logic [NS-1:0] oh;
        logic [NS-1:0] ea;
        oh      = '0;
        oh[stg] = 1'b1;
        ea      = exp_all ? oh : '0;
        i_req   = oh;
        tick();
        i_req = '0;
        total++;
        if (o_grant !== oh || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL blk_grant stage=%0d got grant=%b busy=%b required grant=%b busy=1", stg, o_grant, o_busy, oh);
        end
        for (int k = 0; k < NP; k++) begin
            total++;
            if (o_rom_en !== 1'b1 || o_rom_addr !== a0 + DW'(k)) begin
                bad++;
                $display("FAIL blk_addr stage=%0d k=%0d got en=%b addr=%0d required en=1 addr=%0d",
                         stg, k, o_rom_en, o_rom_addr, a0 + DW'(k));
            end
            total++;
            if (k == 0) begin
                if (o_data_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL blk_first_valid stage=%0d got valid=%b required 0", stg, o_data_valid);
                end
            end else if (o_data_valid !== 1'b1 || o_data_index !== DW'(k - 1) ||
                         o_data !== a0 + DW'(k - 1) + ROM_OFS || o_data_stage !== DW'(stg)) begin
                bad++;
                $display("FAIL blk_data stage=%0d k=%0d got vld=%b idx=%0d data=%0d st=%0d required vld=1 idx=%0d data=%0d st=%0d",
                         stg, k, o_data_valid, o_data_index, o_data, o_data_stage,
                         k - 1, a0 + DW'(k - 1) + ROM_OFS, stg);
            end
            tick();
        end
        total++;
        if (o_rom_en !== 1'b0 || o_data_valid !== 1'b1 || o_data_index !== DW'(NP - 1) ||
            o_data !== a0 + DW'(NP - 1) + ROM_OFS || o_grant !== oh || o_end_single !== '0) begin
            bad++;
            $display("FAIL blk_drain stage=%0d got en=%b vld=%b idx=%0d data=%0d grant=%b es=%b required en=0 vld=1 idx=%0d data=%0d grant=%b es=0",
                     stg, o_rom_en, o_data_valid, o_data_index, o_data, o_grant, o_end_single,
                     NP - 1, a0 + DW'(NP - 1) + ROM_OFS, oh);
        end
        tick();
        total++;
        if (o_end_single !== oh || o_end_all !== ea || o_grant !== '0 || o_busy !== 1'b0 || o_data_valid !== 1'b0) begin
            bad++;
            $display("FAIL blk_end stage=%0d got es=%b ea=%b grant=%b busy=%b vld=%b required es=%b ea=%b grant=0 busy=0 vld=0",
                     stg, o_end_single, o_end_all, o_grant, o_busy, o_data_valid, oh, ea);
        end
        tick();
        total++;
        if (o_end_single !== '0 || o_end_all !== '0) begin
            bad++;
            $display("FAIL blk_pulse_width stage=%0d got es=%b ea=%b required 0", stg, o_end_single, o_end_all);
        end
    endtask

    task automatic test_single;
        run_block(0, 12'd0, 1'b0);
        run_block(0, 12'd3, 1'b1);
        run_block(0, 12'd0, 1'b0);
    endtask

    task automatic test_req_drop;
        run_block(2, 12'd200, 1'b1);
    endtask

    task automatic test_restart_fetch;
        i_req = 4'b0010;
        tick();
        i_req = '0;
        tick();
        total++;
        if (o_rom_en !== 1'b1 || o_rom_addr !== 12'd101) begin
            bad++;
            $display("FAIL rf_second_word got en=%b addr=%0d required en=1 addr=101", o_rom_en, o_rom_addr);
        end
        i_restart = 1'b1;
        tick();
        i_restart = 1'b0;
        total++;
        if (o_rom_en !== 1'b0 || o_grant !== '0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL rf_stop got en=%b grant=%b busy=%b required 0", o_rom_en, o_grant, o_busy);
        end
        total++;
        if (o_data_valid !== 1'b1 || o_data_index !== 12'd1 || o_data !== 12'd101 + ROM_OFS) begin
            bad++;
            $display("FAIL rf_inflight got vld=%b idx=%0d data=%0d required vld=1 idx=1 data=%0d",
                     o_data_valid, o_data_index, o_data, 12'd101 + ROM_OFS);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (o_end_single !== '0 || o_end_all !== '0 || o_data_valid !== 1'b0) begin
                bad++;
                $display("FAIL rf_no_end cycle=%0d got es=%b ea=%b vld=%b required 0", c, o_end_single, o_end_all, o_data_valid);
            end
        end
        run_block(1, 12'd100, 1'b1);
    endtask

    task automatic test_restart_drain;
        i_req = 4'b0001;
        tick();
        i_req = '0;
        repeat (3) tick();
        total++;
        if (o_rom_en !== 1'b0 || o_busy !== 1'b1 || o_grant !== 4'b0001) begin
            bad++;
            $display("FAIL rd_in_drain got en=%b busy=%b grant=%b required en=0 busy=1 grant=0001", o_rom_en, o_busy, o_grant);
        end
        i_restart = 1'b1;
        tick();
        i_restart = 1'b0;
        total++;
        if (o_end_single !== '0 || o_end_all !== '0 || o_grant !== '0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL rd_no_end got es=%b ea=%b grant=%b busy=%b required 0", o_end_single, o_end_all, o_grant, o_busy);
        end
        run_block(0, 12'd0, 1'b0);
        run_block(0, 12'd3, 1'b1);
    endtask

    task automatic test_back_to_back;
        logic [NS-1:0] oh;
        logic [DW-1:0] ea;
        int            stg;
        for (int s = 0; s < NS; s++) num[s] = 12'd4;
        test_reset();
        i_req = 4'b1111;
        tick();
        for (int b = 0; b < 5; b++) begin
            stg     = b % NS;
            oh      = '0;
            oh[stg] = 1'b1;
            ea      = (b == 4) ? 12'd3 : base[stg];
            total++;
            if (o_grant !== oh || o_rom_en !== 1'b1 || o_rom_addr !== ea || o_busy !== 1'b1) begin
                bad++;
                $display("FAIL b2b_grant blk=%0d got grant=%b en=%b addr=%0d busy=%b required grant=%b en=1 addr=%0d busy=1",
                         b, o_grant, o_rom_en, o_rom_addr, o_busy, oh, ea);
            end
            repeat (4) tick();
            total++;
            if (o_end_single !== oh || o_end_all !== '0 || o_grant !== '0 || o_busy !== 1'b0 || o_rom_en !== 1'b0) begin
                bad++;
                $display("FAIL b2b_idle blk=%0d got es=%b ea=%b grant=%b busy=%b en=%b required es=%b ea=0 grant=0 busy=0 en=0",
                         b, o_end_single, o_end_all, o_grant, o_busy, o_rom_en, oh);
            end
            if (b == 4) i_req = '0;
            tick();
        end
        total++;
        if (o_grant !== '0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_release got grant=%b busy=%b required 0", o_grant, o_busy);
        end
    endtask

    task automatic test_async_reset;
        i_req = 4'b0100;
        tick();
        i_req = '0;
        tick();
        total++;
        if (o_rom_en !== 1'b1 || o_grant !== 4'b0100) begin
            bad++;
            $display("FAIL ar_mid_fetch got en=%b grant=%b required en=1 grant=0100", o_rom_en, o_grant);
        end
        #2;
        reset_fpga = 1'b0;
        #1;
        total++;
        if ({o_rom_en, o_busy, o_data_valid, o_grant, o_end_single, o_end_all,
             o_data, o_data_stage, o_data_index, o_rom_addr} !== '0) begin
            bad++;
            $display("FAIL ar_immediate en=%b busy=%b vld=%b grant=%b es=%b ea=%b addr=%0d required all zero",
                     o_rom_en, o_busy, o_data_valid, o_grant, o_end_single, o_end_all, o_rom_addr);
        end
        tick();
        reset_fpga = 1'b1;
        tick();
        total++;
        if (o_end_single !== '0 || o_end_all !== '0 || o_grant !== '0) begin
            bad++;
            $display("FAIL ar_no_end got es=%b ea=%b grant=%b required 0", o_end_single, o_end_all, o_grant);
        end
        i_req = 4'b1010;
        tick();
        i_req = '0;
        total++;
        if (o_grant !== 4'b0010 || o_rom_addr !== 12'd100) begin
            bad++;
            $display("FAIL ar_first_grant got grant=%b addr=%0d required grant=0010 addr=100", o_grant, o_rom_addr);
        end
        repeat (6) tick();
    endtask

    initial begin
        reset_fpga = 1'b0;
        i_restart  = 1'b0;
        i_req      = '0;
        base[0] = 12'd0;   base[1] = 12'd100; base[2] = 12'd200; base[3] = 12'd300;
        num[0]  = 12'd2;   num[1]  = 12'd1;   num[2]  = 12'd1;   num[3]  = 12'd1;
        test_reset();
        test_single();
        test_req_drop();
        test_restart_fetch();
        test_restart_drain();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
